// File: rtl/lc_mbus_bridge_fifo_pkg.sv
// Shared definitions for the LC <-> bus bridge: default widths, FSM encodings
// and FIFO entry sizing ({last, addr, data}).
package lc_mbus_bridge_fifo_pkg;

   localparam int LC_DATA_WIDTH = 32;
   localparam int LC_ADDR_WIDTH = 8;
   localparam int LC_TX_DEPTH   = 4;
   localparam int LC_RX_DEPTH   = 4;

   typedef enum logic [1:0] {
      TX_RSTWAIT = 2'd0,
      TX_IDLE    = 2'd1,
      TX_ACKH    = 2'd2
   } lc_tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE    = 2'd0,
      RX_REQH    = 2'd1,
      RX_ACKWAIT = 2'd2
   } lc_rx_state_t;

   function automatic int lc_entry_width(input int data_w, input int addr_w);
      return data_w + addr_w + 1;
   endfunction

endpackage

// File: rtl/lc_mbus_bridge_fifo_if.sv
// Signal bundle between the bridge (slave) and the LC plus bus TX/RX engines (master).
interface lc_mbus_bridge_fifo_if
   import lc_mbus_bridge_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = LC_DATA_WIDTH,
   parameter int ADDR_WIDTH = LC_ADDR_WIDTH
);
   logic [DATA_WIDTH-1:0] DATA_FROM_LC;
   logic [ADDR_WIDTH-1:0] ADDR_FROM_LC;
   logic                  LAST_FROM_LC;
   logic                  REQ_FROM_LC;
   logic                  ACK_TO_LC;
   logic [DATA_WIDTH-1:0] DATA_TO_LC;
   logic [ADDR_WIDTH-1:0] ADDR_TO_LC;
   logic                  LAST_TO_LC;
   logic                  REQ_TO_LC;
   logic                  ACK_FROM_LC;
   logic                  REQ_TX;
   logic [DATA_WIDTH-1:0] TX_DATA;
   logic [ADDR_WIDTH-1:0] TX_ADDR;
   logic                  DATA_PENDING;
   logic                  TX_ACK;
   logic                  TX_FAIL;
   logic                  RX_VALID;
   logic [DATA_WIDTH-1:0] RX_DATA;
   logic [ADDR_WIDTH-1:0] RX_ADDR;
   logic                  RX_LAST;
   logic                  RX_OVERFLOW;

   modport slave (
      input  DATA_FROM_LC, ADDR_FROM_LC, LAST_FROM_LC, REQ_FROM_LC, ACK_FROM_LC,
             TX_ACK, TX_FAIL, RX_VALID, RX_DATA, RX_ADDR, RX_LAST,
      output ACK_TO_LC, DATA_TO_LC, ADDR_TO_LC, LAST_TO_LC, REQ_TO_LC,
             REQ_TX, TX_DATA, TX_ADDR, DATA_PENDING, RX_OVERFLOW
   );

   modport master (
      output DATA_FROM_LC, ADDR_FROM_LC, LAST_FROM_LC, REQ_FROM_LC, ACK_FROM_LC,
             TX_ACK, TX_FAIL, RX_VALID, RX_DATA, RX_ADDR, RX_LAST,
      input  ACK_TO_LC, DATA_TO_LC, ADDR_TO_LC, LAST_TO_LC, REQ_TO_LC,
             REQ_TX, TX_DATA, TX_ADDR, DATA_PENDING, RX_OVERFLOW
   );

endinterface

// File: rtl/lc_mbus_bridge_fifo_fifo.sv
// Synchronous FIFO with registered count and combinational head (zero when empty).
module lc_mbus_bridge_fifo_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
)(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_empty;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_CNT);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !w_empty;
   assign o_count   = r_count;
   assign o_head    = w_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers are log2(DEPTH) wide and wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/lc_mbus_bridge_fifo.sv
// LC <-> bus bridge: 4-phase LC handshakes in both directions, TX/RX FIFOs,
// and flushing of a failed TX message up to its last word.
module lc_mbus_bridge_fifo
   import lc_mbus_bridge_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = LC_DATA_WIDTH,
   parameter int ADDR_WIDTH = LC_ADDR_WIDTH,
   parameter int TX_DEPTH   = LC_TX_DEPTH,
   parameter int RX_DEPTH   = LC_RX_DEPTH
)(
   input logic                  CLK,
   input logic                  RESET,
   lc_mbus_bridge_fifo_if.slave bus_if
);
   localparam int ENTRY_W = lc_entry_width(DATA_WIDTH, ADDR_WIDTH);
   localparam int TX_CW   = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW   = $clog2(RX_DEPTH) + 1;

   lc_tx_state_t          r_tx_state;
   lc_rx_state_t          r_rx_state;
   logic                  r_ack_to_lc;
   logic                  r_flush;
   logic                  r_req_to_lc;
   logic                  r_last_to_lc;
   logic                  r_rx_overflow;
   logic [DATA_WIDTH-1:0] r_data_to_lc;
   logic [ADDR_WIDTH-1:0] r_addr_to_lc;

   logic [ENTRY_W-1:0]    w_tx_wdata;
   logic [ENTRY_W-1:0]    w_tx_head;
   logic [ENTRY_W-1:0]    w_rx_wdata;
   logic [ENTRY_W-1:0]    w_rx_head;
   logic [TX_CW-1:0]      w_tx_count;
   logic [RX_CW-1:0]      w_rx_count;
   logic                  w_tx_push;
   logic                  w_tx_pop;
   logic                  w_tx_full;
   logic                  w_tx_empty;
   logic                  w_tx_head_last;
   logic                  w_req_tx;
   logic                  w_flush_pop;
   logic                  w_rx_push;
   logic                  w_rx_pop;
   logic                  w_rx_full;
   logic                  w_rx_avail;

   assign w_tx_wdata     = {bus_if.LAST_FROM_LC, bus_if.ADDR_FROM_LC, bus_if.DATA_FROM_LC};
   assign w_tx_empty     = (w_tx_count == '0);
   assign w_tx_head_last = w_tx_head[ENTRY_W-1];
   assign w_req_tx       = !w_tx_empty && !r_flush;
   assign w_tx_push      = (r_tx_state == TX_IDLE) && bus_if.REQ_FROM_LC && !w_tx_full;
   assign w_flush_pop    = r_flush && !w_tx_empty;
   // A simultaneous TX_FAIL suppresses the ACK pop so that head becomes the first flushed word.
   assign w_tx_pop       = w_flush_pop || (w_req_tx && bus_if.TX_ACK && !bus_if.TX_FAIL);

   assign w_rx_wdata = {bus_if.RX_LAST, bus_if.RX_ADDR, bus_if.RX_DATA};
   assign w_rx_push  = bus_if.RX_VALID && !w_rx_full;
   assign w_rx_pop   = (r_rx_state == RX_REQH) && bus_if.ACK_FROM_LC;
   assign w_rx_avail = (w_rx_count != '0);

   lc_mbus_bridge_fifo_fifo #(.WIDTH(ENTRY_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_push  (w_tx_push),
      .i_data  (w_tx_wdata),
      .i_pop   (w_tx_pop),
      .o_head  (w_tx_head),
      .o_full  (w_tx_full),
      .o_count (w_tx_count)
   );

   lc_mbus_bridge_fifo_fifo #(.WIDTH(ENTRY_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_push  (w_rx_push),
      .i_data  (w_rx_wdata),
      .i_pop   (w_rx_pop),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_count (w_rx_count)
   );

   // RSTWAIT keeps a request that straddled reset from being written twice.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_tx_state  <= TX_RSTWAIT;
         r_ack_to_lc <= 1'b0;
      end else begin
         case (r_tx_state)
            TX_RSTWAIT: begin
               r_ack_to_lc <= 1'b0;
               if (!bus_if.REQ_FROM_LC) begin
                  r_tx_state <= TX_IDLE;
               end
            end
            TX_IDLE: begin
               if (w_tx_push) begin
                  r_ack_to_lc <= 1'b1;
                  r_tx_state  <= TX_ACKH;
               end
            end
            TX_ACKH: begin
               if (!bus_if.REQ_FROM_LC) begin
                  r_ack_to_lc <= 1'b0;
                  r_tx_state  <= TX_IDLE;
               end
            end
            default: begin
               r_ack_to_lc <= 1'b0;
               r_tx_state  <= TX_RSTWAIT;
            end
         endcase
      end
   end

   // Flush stays armed across an empty FIFO until the failed message's last word is popped.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_flush <= 1'b0;
      end else if (bus_if.TX_FAIL) begin
         r_flush <= 1'b1;
      end else if (w_flush_pop && w_tx_head_last) begin
         r_flush <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rx_overflow <= 1'b0;
      end else if (bus_if.RX_VALID && w_rx_full) begin
         r_rx_overflow <= 1'b1;
      end
   end

   // IDLE also waits for ACK_FROM_LC low so a handshake cut by reset cannot complete a new word.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rx_state   <= RX_IDLE;
         r_req_to_lc  <= 1'b0;
         r_data_to_lc <= '0;
         r_addr_to_lc <= '0;
         r_last_to_lc <= 1'b0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               if (w_rx_avail && !bus_if.ACK_FROM_LC) begin
                  r_data_to_lc <= w_rx_head[DATA_WIDTH-1:0];
                  r_addr_to_lc <= w_rx_head[DATA_WIDTH +: ADDR_WIDTH];
                  r_last_to_lc <= w_rx_head[ENTRY_W-1];
                  r_req_to_lc  <= 1'b1;
                  r_rx_state   <= RX_REQH;
               end
            end
            RX_REQH: begin
               if (bus_if.ACK_FROM_LC) begin
                  r_req_to_lc <= 1'b0;
                  r_rx_state  <= RX_ACKWAIT;
               end
            end
            RX_ACKWAIT: begin
               if (!bus_if.ACK_FROM_LC) begin
                  r_rx_state <= RX_IDLE;
               end
            end
            default: begin
               r_req_to_lc <= 1'b0;
               r_rx_state  <= RX_IDLE;
            end
         endcase
      end
   end

   assign bus_if.ACK_TO_LC    = r_ack_to_lc;
   assign bus_if.REQ_TX       = w_req_tx;
   assign bus_if.TX_DATA      = w_tx_head[DATA_WIDTH-1:0];
   assign bus_if.TX_ADDR      = w_tx_head[DATA_WIDTH +: ADDR_WIDTH];
   assign bus_if.DATA_PENDING = !w_tx_empty && !w_tx_head_last;
   assign bus_if.REQ_TO_LC    = r_req_to_lc;
   assign bus_if.DATA_TO_LC   = r_data_to_lc;
   assign bus_if.ADDR_TO_LC   = r_addr_to_lc;
   assign bus_if.LAST_TO_LC   = r_last_to_lc;
   assign bus_if.RX_OVERFLOW  = r_rx_overflow;

endmodule

// File: tb/tb_lc_mbus_bridge_fifo.sv
// Directed bench for lc_mbus_bridge_fifo: LC TX handshake, TX full, flush, RX overflow,
// simultaneous bus events and reset in the middle of handshakes.
module tb_lc_mbus_bridge_fifo;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   lc_mbus_bridge_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bif ();

   lc_mbus_bridge_fifo #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (8),
      .TX_DEPTH   (4),
      .RX_DEPTH   (4)
   ) dut (
      .CLK    (clk),
      .RESET  (rst),
      .bus_if (bif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack_to_lc(input logic lvl, input string tag);
      int n = 0;
      while (bif.ACK_TO_LC !== lvl && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 64'(bif.ACK_TO_LC), 64'(lvl));
   endtask

   task automatic wait_req_to_lc(input logic lvl, input string tag);
      int n = 0;
      while (bif.REQ_TO_LC !== lvl && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 64'(bif.REQ_TO_LC), 64'(lvl));
   endtask

   task automatic lc_push(input logic [31:0] d, input logic [7:0] a, input logic l, input string tag);
      bif.DATA_FROM_LC = d;
      bif.ADDR_FROM_LC = a;
      bif.LAST_FROM_LC = l;
      bif.REQ_FROM_LC  = 1'b1;
      wait_ack_to_lc(1'b1, {tag, "_ack_hi"});
      bif.REQ_FROM_LC  = 1'b0;
      wait_ack_to_lc(1'b0, {tag, "_ack_lo"});
   endtask

   task automatic tx_ack_pulse();
      bif.TX_ACK = 1'b1;
      tick();
      bif.TX_ACK = 1'b0;
   endtask

   task automatic rx_pulse(input logic [31:0] d, input logic [7:0] a, input logic l);
      bif.RX_VALID = 1'b1;
      bif.RX_DATA  = d;
      bif.RX_ADDR  = a;
      bif.RX_LAST  = l;
      tick();
      bif.RX_VALID = 1'b0;
   endtask

   task automatic rx_take(input logic [31:0] d, input logic [7:0] a, input logic l, input string tag);
      wait_req_to_lc(1'b1, {tag, "_req_hi"});
      chk({tag, "_data"}, 64'(bif.DATA_TO_LC), 64'(d));
      chk({tag, "_addr"}, 64'(bif.ADDR_TO_LC), 64'(a));
      chk({tag, "_last"}, 64'(bif.LAST_TO_LC), 64'(l));
      bif.ACK_FROM_LC = 1'b1;
      wait_req_to_lc(1'b0, {tag, "_req_lo"});
      chk({tag, "_hold"}, 64'(bif.DATA_TO_LC), 64'(d));
      bif.ACK_FROM_LC = 1'b0;
      tick();
   endtask

   initial begin
      rst              = 1'b1;
      bif.DATA_FROM_LC = '0;
      bif.ADDR_FROM_LC = '0;
      bif.LAST_FROM_LC = 1'b0;
      bif.REQ_FROM_LC  = 1'b0;
      bif.ACK_FROM_LC  = 1'b0;
      bif.TX_ACK       = 1'b0;
      bif.TX_FAIL      = 1'b0;
      bif.RX_VALID     = 1'b0;
      bif.RX_DATA      = '0;
      bif.RX_ADDR      = '0;
      bif.RX_LAST      = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_ack_to_lc", 64'(bif.ACK_TO_LC), 64'd0);
      chk("rst_req_tx", 64'(bif.REQ_TX), 64'd0);
      chk("rst_tx_data", 64'(bif.TX_DATA), 64'd0);
      chk("rst_data_pending", 64'(bif.DATA_PENDING), 64'd0);
      chk("rst_req_to_lc", 64'(bif.REQ_TO_LC), 64'd0);
      chk("rst_data_to_lc", 64'(bif.DATA_TO_LC), 64'd0);
      chk("rst_overflow", 64'(bif.RX_OVERFLOW), 64'd0);
      rst = 1'b0;
      tick();

      // single word, ACK one cycle after the write edge
      bif.DATA_FROM_LC = 32'hDEADBEEF;
      bif.ADDR_FROM_LC = 8'h5A;
      bif.LAST_FROM_LC = 1'b1;
      bif.REQ_FROM_LC  = 1'b1;
      tick();
      chk("single_ack", 64'(bif.ACK_TO_LC), 64'd1);
      chk("single_req_tx", 64'(bif.REQ_TX), 64'd1);
      chk("single_tx_data", 64'(bif.TX_DATA), 64'hDEADBEEF);
      chk("single_tx_addr", 64'(bif.TX_ADDR), 64'h5A);
      chk("single_pending", 64'(bif.DATA_PENDING), 64'd0);
      bif.REQ_FROM_LC = 1'b0;
      tick();
      chk("single_ack_lo", 64'(bif.ACK_TO_LC), 64'd0);
      tx_ack_pulse();
      chk("single_req_tx_lo", 64'(bif.REQ_TX), 64'd0);
      chk("single_tx_data_lo", 64'(bif.TX_DATA), 64'd0);

      // TX full: fifth request stalls until one pop
      for (int i = 0; i < 4; i++) begin
         lc_push(32'(32'h1000 + i), 8'(i), 1'b1, "full_fill");
      end
      bif.DATA_FROM_LC = 32'h1004;
      bif.ADDR_FROM_LC = 8'h04;
      bif.LAST_FROM_LC = 1'b1;
      bif.REQ_FROM_LC  = 1'b1;
      repeat (4) tick();
      chk("full_no_ack", 64'(bif.ACK_TO_LC), 64'd0);
      chk("full_head0", 64'(bif.TX_DATA), 64'h1000);
      bif.TX_ACK = 1'b1;
      tick();
      bif.TX_ACK = 1'b0;
      chk("full_no_ack_pop_edge", 64'(bif.ACK_TO_LC), 64'd0);
      tick();
      chk("full_fifth_ack", 64'(bif.ACK_TO_LC), 64'd1);
      bif.REQ_FROM_LC = 1'b0;
      wait_ack_to_lc(1'b0, "full_fifth_ack_lo");
      for (int i = 1; i < 5; i++) begin
         chk("full_order", 64'(bif.TX_DATA), 64'(32'h1000 + i));
         tx_ack_pulse();
      end
      chk("full_drained", 64'(bif.REQ_TX), 64'd0);

      // flush of a failed 3-word message, next message survives
      lc_push(32'hA1, 8'h11, 1'b0, "fl_w1");
      lc_push(32'hA2, 8'h11, 1'b0, "fl_w2");
      lc_push(32'hA3, 8'h11, 1'b1, "fl_w3");
      lc_push(32'hB1, 8'h22, 1'b1, "fl_n1");
      chk("fl_pending_w1", 64'(bif.DATA_PENDING), 64'd1);
      tx_ack_pulse();
      chk("fl_head_w2", 64'(bif.TX_DATA), 64'hA2);
      bif.TX_FAIL = 1'b1;
      tick();
      bif.TX_FAIL = 1'b0;
      chk("fl_req_tx_off", 64'(bif.REQ_TX), 64'd0);
      chk("fl_head_still_w2", 64'(bif.TX_DATA), 64'hA2);
      tick();
      chk("fl_req_tx_off2", 64'(bif.REQ_TX), 64'd0);
      chk("fl_head_w3", 64'(bif.TX_DATA), 64'hA3);
      tick();
      chk("fl_req_tx_next", 64'(bif.REQ_TX), 64'd1);
      chk("fl_head_next", 64'(bif.TX_DATA), 64'hB1);
      chk("fl_addr_next", 64'(bif.TX_ADDR), 64'h22);
      chk("fl_pending_next", 64'(bif.DATA_PENDING), 64'd0);
      tx_ack_pulse();
      chk("fl_drained", 64'(bif.REQ_TX), 64'd0);

      // flush with empty FIFO discards the LC message as it arrives
      bif.TX_FAIL = 1'b1;
      tick();
      bif.TX_FAIL = 1'b0;
      lc_push(32'hC1, 8'h33, 1'b0, "fe_w1");
      lc_push(32'hC2, 8'h33, 1'b1, "fe_w2");
      chk("fe_discarded", 64'(bif.REQ_TX), 64'd0);
      lc_push(32'hC3, 8'h34, 1'b1, "fe_w3");
      chk("fe_next_req", 64'(bif.REQ_TX), 64'd1);
      chk("fe_next_data", 64'(bif.TX_DATA), 64'hC3);
      tx_ack_pulse();

      // TX_ACK with TX_FAIL: fail wins, head flushed first
      lc_push(32'hD1, 8'h44, 1'b1, "sim_w1");
      lc_push(32'hD2, 8'h44, 1'b1, "sim_w2");
      bif.TX_ACK  = 1'b1;
      bif.TX_FAIL = 1'b1;
      tick();
      bif.TX_ACK  = 1'b0;
      bif.TX_FAIL = 1'b0;
      chk("sim_fail_wins_req", 64'(bif.REQ_TX), 64'd0);
      chk("sim_fail_wins_head", 64'(bif.TX_DATA), 64'hD1);
      tick();
      chk("sim_after_flush_req", 64'(bif.REQ_TX), 64'd1);
      chk("sim_after_flush_head", 64'(bif.TX_DATA), 64'hD2);

      // push and pop on the same edge: count unchanged at one
      bif.DATA_FROM_LC = 32'hD3;
      bif.ADDR_FROM_LC = 8'h45;
      bif.LAST_FROM_LC = 1'b1;
      bif.REQ_FROM_LC  = 1'b1;
      bif.TX_ACK       = 1'b1;
      tick();
      bif.TX_ACK = 1'b0;
      chk("pp_ack", 64'(bif.ACK_TO_LC), 64'd1);
      chk("pp_req_tx", 64'(bif.REQ_TX), 64'd1);
      chk("pp_head", 64'(bif.TX_DATA), 64'hD3);
      bif.REQ_FROM_LC = 1'b0;
      wait_ack_to_lc(1'b0, "pp_ack_lo");
      tx_ack_pulse();
      chk("pp_single_entry", 64'(bif.REQ_TX), 64'd0);

      // RX burst of 5 into a 4-deep FIFO with a stalled LC
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            chk("rx_no_overflow_yet", 64'(bif.RX_OVERFLOW), 64'd0);
         end
         rx_pulse(32'(32'hE0 + i), 8'(8'h70 + i), (i >= 3) ? 1'b1 : 1'b0);
      end
      chk("rx_overflow", 64'(bif.RX_OVERFLOW), 64'd1);
      for (int i = 0; i < 4; i++) begin
         rx_take(32'(32'hE0 + i), 8'(8'h70 + i), (i == 3) ? 1'b1 : 1'b0, "rx_word");
      end
      repeat (3) tick();
      chk("rx_no_fifth", 64'(bif.REQ_TO_LC), 64'd0);
      chk("rx_overflow_sticky", 64'(bif.RX_OVERFLOW), 64'd1);

      // reset in the middle of both handshakes
      bif.DATA_FROM_LC = 32'hF1;
      bif.ADDR_FROM_LC = 8'h55;
      bif.LAST_FROM_LC = 1'b1;
      bif.REQ_FROM_LC  = 1'b1;
      wait_ack_to_lc(1'b1, "mr_ack_hi");
      rx_pulse(32'hF9, 8'h66, 1'b1);
      wait_req_to_lc(1'b1, "mr_rx_req_hi");
      rst             = 1'b1;
      bif.ACK_FROM_LC = 1'b1;
      tick();
      chk("mr_ack_to_lc", 64'(bif.ACK_TO_LC), 64'd0);
      chk("mr_req_tx", 64'(bif.REQ_TX), 64'd0);
      chk("mr_tx_data", 64'(bif.TX_DATA), 64'd0);
      chk("mr_req_to_lc", 64'(bif.REQ_TO_LC), 64'd0);
      chk("mr_data_to_lc", 64'(bif.DATA_TO_LC), 64'd0);
      chk("mr_overflow_clr", 64'(bif.RX_OVERFLOW), 64'd0);
      rst = 1'b0;
      repeat (3) tick();
      chk("mr_no_dup_ack", 64'(bif.ACK_TO_LC), 64'd0);
      chk("mr_no_dup_write", 64'(bif.REQ_TX), 64'd0);
      rx_pulse(32'hFA, 8'h67, 1'b0);
      repeat (2) tick();
      chk("mr_rx_wait_ack_lo", 64'(bif.REQ_TO_LC), 64'd0);
      bif.ACK_FROM_LC = 1'b0;
      bif.REQ_FROM_LC = 1'b0;
      tick();
      chk("mr_rx_req_after", 64'(bif.REQ_TO_LC), 64'd1);
      chk("mr_rx_data_after", 64'(bif.DATA_TO_LC), 64'hFA);
      lc_push(32'hF2, 8'h56, 1'b1, "mr_new");
      chk("mr_new_req_tx", 64'(bif.REQ_TX), 64'd1);
      chk("mr_new_tx_data", 64'(bif.TX_DATA), 64'hF2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
